lfsr_gen: RTL and testbench
===========================

LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 Parameter WIDTH, default 5, legal 3..32: LFSR state width.
REQ-002 Parameter TAPS, default 5'h14 (x^5+x^3+1), WIDTH bits: feedback tap mask, bit i = state bit i tapped.
REQ-003 Parameter SEED, default all-ones: reset state and substitute for an all-zero load.
REQ-004 clk  in  1  single clock, all logic rising-edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 en  in  1  advance the LFSR one step this cycle.
REQ-007 load  in  1  load seed_in this cycle, priority over en.
REQ-008 seed_in  in  WIDTH  seed value for load.
REQ-009 data  out  WIDTH  registered LFSR state.
REQ-010 bit_out  out  1  serial output, equal to data[WIDTH-1].
REQ-011 zero_seed  out  1  sticky flag: an all-zero seed was rejected.
REQ-012 wrap  out  1  one-cycle pulse: sequence returned to its start value (LFSR_CNT_EN only).
REQ-013 step_cnt  out  WIDTH  advances since last load/reset/wrap (LFSR_CNT_EN only).

Function
REQ-014 Feedback fb SHALL be XOR-reduce(data & TAPS); next state SHALL be {data[WIDTH-2:0], fb}.
REQ-015 en=1, load=0: data SHALL update to next state on the same clock edge; latency 1 cycle.
REQ-016 en=0, load=0: data, step_cnt, zero_seed SHALL hold; wrap SHALL be 0.
REQ-017 load=1: data SHALL take seed_in next cycle regardless of en; no advance that cycle.
REQ-018 load=1 with seed_in==0: data SHALL take SEED, zero_seed SHALL set to 1.
REQ-019 zero_seed SHALL clear only on rst.
REQ-020 Internal start register SHALL capture the value written into data on every load and on reset.
REQ-021 step_cnt SHALL increment by 1 on each advance, clear to 0 on load.
REQ-022 step_cnt SHALL saturate at all-ones (non-maximal TAPS) and not wrap to zero.
REQ-023 wrap SHALL be 1 in the cycle after an advance whose next state equals the start register; step_cnt SHALL clear to 0 on that same edge.
REQ-024 wrap SHALL NOT assert on a load, even if seed_in equals the current data.
REQ-025 All-zero data SHALL be unreachable: reset and load never produce it, shift with XOR feedback preserves non-zero.
REQ-026 bit_out SHALL be combinational from data, no extra register.

Reset
REQ-027 rst=1 SHALL set data=SEED, start register=SEED, step_cnt=0, wrap=0, zero_seed=0 on next edge.
REQ-028 rst SHALL override load and en in the same cycle.
REQ-029 rst asserted mid-sequence SHALL discard all state; first advance after release SHALL produce next state of SEED.

Configuration
REQ-030 Macro LFSR_CNT_EN defined: start register, step_cnt, wrap logic SHALL be present per REQ-020..024.
REQ-031 LFSR_CNT_EN undefined: start register and counter SHALL be absent, wrap tied 0, step_cnt tied 0; data/bit_out/zero_seed behaviour unchanged.

Verification
REQ-032 Defaults, rst 1 cycle then en=1 for 31 cycles -> data sequence 1F,1E,1C,18,11,...; after 31 advances data=1F, wrap=1 for exactly one cycle, step_cnt=0.
REQ-033 load=1, seed_in=5'h00 -> data=1F next cycle, zero_seed=1 and stays 1 through 100 further advances until rst.
REQ-034 load=1 and en=1 together, seed_in=5'h05 -> data=05 next cycle (no advance), step_cnt=0, wrap=0.
REQ-035 en toggled 0/1 each cycle for 62 cycles after rst -> data advances only on en=1 cycles; wrap once at the 31st advance.
REQ-036 rst asserted mid-sequence with load=1 and en=1 -> data=1F, step_cnt=0, wrap=0, zero_seed=0 next cycle.
REQ-037 Build with LFSR_CNT_EN undefined, repeat REQ-032 -> identical data sequence, wrap and step_cnt constant 0.

Source files
------------

// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - Fibonacci-style LFSR with seed load, zero-seed guard, optional wrap/step counter.
// Optional feature macro: LFSR_CNT_EN enables the start register, step counter and wrap pulse.
module lfsr_gen #(
    parameter int               WIDTH = 5,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(5'h14),
    parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] data,
    output logic             bit_out,
    output logic             zero_seed,
    output logic             wrap,
    output logic [WIDTH-1:0] step_cnt
);

    logic [WIDTH-1:0] r_data;
    logic             r_zero_seed;
    logic             w_fb;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_load_val;
    logic             w_seed_zero;

    assign w_fb        = ^(r_data & TAPS);
    assign w_next      = {r_data[WIDTH-2:0], w_fb};
    assign w_seed_zero = (seed_in == '0);
    // An all-zero seed would lock the LFSR, so SEED is substituted.
    assign w_load_val  = w_seed_zero ? SEED : seed_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data      <= SEED;
            r_zero_seed <= 1'b0;
        end else if (load) begin
            r_data <= w_load_val;
            if (w_seed_zero) begin
                r_zero_seed <= 1'b1;
            end
        end else if (en) begin
            r_data <= w_next;
        end
    end

    assign data      = r_data;
    assign bit_out   = r_data[WIDTH-1];
    assign zero_seed = r_zero_seed;

`ifdef LFSR_CNT_EN
    logic [WIDTH-1:0] r_start;
    logic [WIDTH-1:0] r_cnt;
    logic             r_wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_start <= SEED;
            r_cnt   <= '0;
            r_wrap  <= 1'b0;
        end else if (load) begin
            r_start <= w_load_val;
            r_cnt   <= '0;
            r_wrap  <= 1'b0;
        end else if (en) begin
            if (w_next == r_start) begin
                r_wrap <= 1'b1;
                r_cnt  <= '0;
            end else begin
                r_wrap <= 1'b0;
                // Non-maximal taps may never return to start; hold at all-ones.
                if (r_cnt != {WIDTH{1'b1}}) begin
                    r_cnt <= r_cnt + WIDTH'(1);
                end
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign wrap     = r_wrap;
    assign step_cnt = r_cnt;
`else
    assign wrap     = 1'b0;
    assign step_cnt = '0;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// tb/tb_lfsr_gen.sv - Self-checking bench for lfsr_gen with a behavioural reference model.
module tb_lfsr_gen;

    localparam logic [4:0] TP = 5'h14;
    localparam logic [4:0] SD = 5'h1F;
`ifdef LFSR_CNT_EN
    localparam int CNT = 1;
`else
    localparam int CNT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [4:0] seed_in = 5'h00;
    logic [4:0] data;
    logic       bit_out;
    logic       zero_seed;
    logic       wrap;
    logic [4:0] step_cnt;

    int checks = 0;
    int errors = 0;

    lfsr_gen dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .seed_in  (seed_in),
        .data     (data),
        .bit_out  (bit_out),
        .zero_seed(zero_seed),
        .wrap     (wrap),
        .step_cnt (step_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Next state as arithmetic: double the value, add tap parity, keep 5 bits.
    function automatic int lfsr_next(input int d);
        int p;
        p = $countones(5'(d) & TP);
        return (d * 2 + (p % 2)) % 32;
    endfunction

    int m_data, m_start, m_cnt, m_wrap, m_zero;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        int v;
        if (rst) begin
            m_data = SD; m_start = SD; m_cnt = 0; m_wrap = 0; m_zero = 0;
            m_valid = 1'b1;
        end else if (load) begin
            v = (seed_in == 5'h00) ? int'(SD) : int'(seed_in);
            if (seed_in == 5'h00) m_zero = 1;
            m_data = v; m_start = v; m_cnt = 0; m_wrap = 0;
        end else if (en) begin
            m_data = lfsr_next(m_data);
            if (m_data == m_start) begin
                m_wrap = 1; m_cnt = 0;
            end else begin
                m_wrap = 0;
                m_cnt = (m_cnt < 31) ? m_cnt + 1 : 31;
            end
        end else begin
            m_wrap = 0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_data", int'(data), m_data);
            chk("model_bit_out", int'(bit_out), (m_data / 16) % 2);
            chk("model_zero_seed", int'(zero_seed), m_zero);
            chk("model_wrap", int'(wrap), m_wrap * CNT);
            chk("model_step_cnt", int'(step_cnt), m_cnt * CNT);
        end
    end

    task automatic cyc(input logic r, input logic l, input logic e, input logic [4:0] s);
        rst = r; load = l; en = e; seed_in = s;
        @(posedge clk);
        @(negedge clk);
    endtask

    int nwrap;
    logic [4:0] first_vals [5];

    initial begin
        first_vals[0] = 5'h1E; first_vals[1] = 5'h1C; first_vals[2] = 5'h18;
        first_vals[3] = 5'h11; first_vals[4] = 5'h03;
        @(negedge clk);

        cyc(1, 0, 0, 5'h00);
        chk("reset_data", int'(data), 'h1F);
        chk("reset_step_cnt", int'(step_cnt), 0);
        chk("reset_wrap", int'(wrap), 0);
        chk("reset_zero_seed", int'(zero_seed), 0);

        nwrap = 0;
        for (int i = 0; i < 31; i++) begin
            cyc(0, 0, 1, 5'h00);
            if (i < 5) chk("seq_literal", int'(data), int'(first_vals[i]));
            if (wrap) nwrap++;
        end
        chk("seq31_data", int'(data), 'h1F);
        chk("seq31_wrap", int'(wrap), CNT);
        chk("seq31_step_cnt", int'(step_cnt), 0);
        chk("seq31_wrap_count", nwrap, CNT);
        cyc(0, 0, 0, 5'h00);
        chk("wrap_one_cycle", int'(wrap), 0);

        cyc(0, 1, 0, 5'h00);
        chk("zero_load_data", int'(data), 'h1F);
        chk("zero_load_flag", int'(zero_seed), 1);
        for (int i = 0; i < 100; i++) cyc(0, 0, 1, 5'h00);
        chk("zero_flag_sticky", int'(zero_seed), 1);
        cyc(1, 0, 0, 5'h00);
        chk("zero_flag_rst", int'(zero_seed), 0);

        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 5'h00);
        cyc(0, 1, 1, 5'h05);
        chk("load_en_data", int'(data), 'h05);
        chk("load_en_step_cnt", int'(step_cnt), 0);
        chk("load_en_wrap", int'(wrap), 0);
        cyc(0, 1, 0, 5'h05);
        chk("load_same_wrap", int'(wrap), 0);

        cyc(1, 0, 0, 5'h00);
        nwrap = 0;
        for (int i = 0; i < 62; i++) begin
            cyc(0, 0, 1'(i % 2), 5'h00);
            if (wrap) nwrap++;
        end
        chk("toggle_data", int'(data), 'h1F);
        chk("toggle_wrap_count", nwrap, CNT);

        for (int i = 0; i < 7; i++) cyc(0, 0, 1, 5'h00);
        cyc(0, 1, 0, 5'h00);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 5'h00);
        cyc(1, 1, 1, 5'h0A);
        chk("rst_over_data", int'(data), 'h1F);
        chk("rst_over_step_cnt", int'(step_cnt), 0);
        chk("rst_over_wrap", int'(wrap), 0);
        chk("rst_over_zero_seed", int'(zero_seed), 0);
        cyc(0, 0, 1, 5'h00);
        chk("rst_first_adv", int'(data), 'h1E);

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 150) == 0,
                ($urandom % 12) == 0,
                1'($urandom % 2),
                (($urandom % 4) == 0) ? 5'h00 : 5'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
